// File: rtl/sdram_pro_arbit.sv
// SDRAM command arbiter: init, refresh, write and read modules share the SDRAM pins.
// Optional macro ARBIT_RR_EN alternates write/read priority; refresh always stays highest.
module sdram_pro_arbit #(
  parameter int ARB_TIMEOUT = 1024,
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              atref_req,
  input  logic              atref_end,
  input  logic [3:0]        atref_cmd,
  input  logic [BANK_W-1:0] atref_bank,
  input  logic [ADDR_W-1:0] atref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              atref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              arb_err,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr
);

  localparam int CNT_W = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((ARB_TIMEOUT > 0) ? ARB_TIMEOUT - 1 : 0);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_ATREF = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_s;
  logic [CNT_W-1:0]  wd_cnt_r;
  logic              wd_hit_s;
  logic              timeout_s;
  logic              owner_s;
  logic              atref_blk_r;
  logic              wr_blk_r;
  logic              rd_blk_r;
  logic              atref_ok_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              rd_first_s;
  logic [3:0]        cmd_s;

  // A requester that stalled into a timeout stays masked until it drops its request.
  assign atref_ok_s = atref_req & ~atref_blk_r;
  assign wr_ok_s    = wr_req & ~wr_blk_r;
  assign rd_ok_s    = rd_req & ~rd_blk_r;
  assign wd_hit_s   = (ARB_TIMEOUT > 0) && (wd_cnt_r == WD_LAST);
  assign owner_s    = (state_r == ST_ATREF) || (state_r == ST_WRITE) || (state_r == ST_READ);

`ifdef ARBIT_RR_EN
  logic rr_rd_first_r;

  // Round-robin pointer: the side granted last loses the next write/read tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_rd_first_r <= 1'b0;
    end else if ((state_r == ST_ARBIT) && (next_s == ST_WRITE)) begin
      rr_rd_first_r <= 1'b1;
    end else if ((state_r == ST_ARBIT) && (next_s == ST_READ)) begin
      rr_rd_first_r <= 1'b0;
    end else begin
      rr_rd_first_r <= rr_rd_first_r;
    end
  end

  assign rd_first_s = rr_rd_first_r;
`else
  assign rd_first_s = 1'b0;
`endif

  // Next-state selection, including the watchdog escape from owner states.
  always_comb begin
    next_s    = state_r;
    timeout_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_end) next_s = ST_ARBIT;
        else          next_s = ST_INIT;
      end
      ST_ARBIT: begin
        if (atref_ok_s)              next_s = ST_ATREF;
        else if (wr_ok_s && rd_ok_s) next_s = rd_first_s ? ST_READ : ST_WRITE;
        else if (wr_ok_s)            next_s = ST_WRITE;
        else if (rd_ok_s)            next_s = ST_READ;
        else                         next_s = ST_ARBIT;
      end
      ST_ATREF: begin
        if (atref_end) begin
          next_s = ST_ARBIT;
        end else if (wd_hit_s) begin
          next_s    = ST_ARBIT;
          timeout_s = 1'b1;
        end else begin
          next_s = ST_ATREF;
        end
      end
      ST_WRITE: begin
        if (wr_end) begin
          next_s = ST_ARBIT;
        end else if (wd_hit_s) begin
          next_s    = ST_ARBIT;
          timeout_s = 1'b1;
        end else begin
          next_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (rd_end) begin
          next_s = ST_ARBIT;
        end else if (wd_hit_s) begin
          next_s    = ST_ARBIT;
          timeout_s = 1'b1;
        end else begin
          next_s = ST_READ;
        end
      end
      default: begin
        next_s = ST_INIT;
      end
    endcase
  end

  // State register, one-cycle grant pulses, sticky error and watchdog counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r  <= ST_INIT;
      atref_en <= 1'b0;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      arb_err  <= 1'b0;
      wd_cnt_r <= '0;
    end else begin
      state_r  <= next_s;
      atref_en <= (state_r == ST_ARBIT) && (next_s == ST_ATREF);
      wr_en    <= (state_r == ST_ARBIT) && (next_s == ST_WRITE);
      rd_en    <= (state_r == ST_ARBIT) && (next_s == ST_READ);
      arb_err  <= arb_err | timeout_s;
      if (next_s != state_r) begin
        wd_cnt_r <= '0;
      end else if (owner_s && (ARB_TIMEOUT > 0)) begin
        wd_cnt_r <= wd_cnt_r + CNT_W'(1'b1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end
  end

  // Timeout masks: set on the stalled owner, released once its request is low.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      atref_blk_r <= 1'b0;
      wr_blk_r    <= 1'b0;
      rd_blk_r    <= 1'b0;
    end else begin
      atref_blk_r <= (timeout_s && (state_r == ST_ATREF)) | (atref_blk_r & atref_req);
      wr_blk_r    <= (timeout_s && (state_r == ST_WRITE)) | (wr_blk_r & wr_req);
      rd_blk_r    <= (timeout_s && (state_r == ST_READ))  | (rd_blk_r & rd_req);
    end
  end

  // Pin mux follows the state register; ARBIT drives NOP with all-ones bank/address.
  always_comb begin
    cmd_s      = init_cmd;
    sdram_ba   = init_bank;
    sdram_addr = init_addr;
    case (state_r)
      ST_INIT: begin
        cmd_s      = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      ST_ARBIT: begin
        cmd_s      = CMD_NOP;
        sdram_ba   = {BANK_W{1'b1}};
        sdram_addr = {ADDR_W{1'b1}};
      end
      ST_ATREF: begin
        cmd_s      = atref_cmd;
        sdram_ba   = atref_bank;
        sdram_addr = atref_addr;
      end
      ST_WRITE: begin
        cmd_s      = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        cmd_s      = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd_s      = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Randomized scoreboard bench for sdram_pro_arbit: a transaction-level ownership model
// predicts grants, pin contents and arb_err; a negedge monitor compares against the DUT.
module tb_sdram_pro_arbit;

  localparam int TO = 16;
  localparam int AW = 12;
  localparam int BW = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          init_end = 1'b0;
  logic          req  [4];
  logic          endp [4];
  logic [3:0]    cmd  [4];
  logic [BW-1:0] bank [4];
  logic [AW-1:0] addr [4];

  logic atref_req, atref_end, wr_req, wr_end, rd_req, rd_end;
  logic atref_en, wr_en, rd_en, arb_err, sdram_cke;
  logic sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BW-1:0] sdram_ba;
  logic [AW-1:0] sdram_addr;

  assign atref_req = req[1];
  assign wr_req    = req[2];
  assign rd_req    = req[3];
  assign atref_end = endp[1];
  assign wr_end    = endp[2];
  assign rd_end    = endp[3];

  always #5 sys_clk = ~sys_clk;

  sdram_pro_arbit #(.ARB_TIMEOUT(TO), .ADDR_W(AW), .BANK_W(BW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_end(init_end), .init_cmd(cmd[0]), .init_bank(bank[0]), .init_addr(addr[0]),
    .atref_req(atref_req), .atref_end(atref_end),
    .atref_cmd(cmd[1]), .atref_bank(bank[1]), .atref_addr(addr[1]),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(cmd[2]), .wr_bank(bank[2]), .wr_addr(addr[2]),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(cmd[3]), .rd_bank(bank[3]), .rd_addr(addr[3]),
    .atref_en(atref_en), .wr_en(wr_en), .rd_en(rd_en), .arb_err(arb_err),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
  );

  typedef struct {
    int id;
    int cyc;
  } grant_t;

  grant_t exp_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  bit     mon_on = 1'b0;

  // Reference model: who owns the bus (0 = nobody), for how long, and who is masked.
  bit m_init_done = 1'b0;
  int m_owner = 0;
  int m_ten = 0;
  bit m_err = 1'b0;
  bit m_blk [4];
  bit m_rd_first = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge sys_clk) begin
    bit elig [4];
    int pick;
    int stalled;
    cyc++;
    if (sys_rst) begin
      m_init_done = 1'b0;
      m_owner     = 0;
      m_ten       = 0;
      m_err       = 1'b0;
      m_rd_first  = 1'b0;
      for (int i = 0; i < 4; i++) m_blk[i] = 1'b0;
    end else begin
      stalled = 0;
      for (int i = 1; i < 4; i++) elig[i] = req[i] && !m_blk[i];
      if (!m_init_done) begin
        m_init_done = init_end;
      end else if (m_owner == 0) begin
        pick = 0;
        if (elig[1])                pick = 1;
        else if (elig[2] && elig[3]) pick = m_rd_first ? 3 : 2;
        else if (elig[2])           pick = 2;
        else if (elig[3])           pick = 3;
        if (pick != 0) begin
          m_owner = pick;
          m_ten   = 0;
          exp_q.push_back('{pick, cyc});
`ifdef ARBIT_RR_EN
          if (pick == 2) m_rd_first = 1'b1;
          else if (pick == 3) m_rd_first = 1'b0;
`endif
        end
      end else if (endp[m_owner]) begin
        m_owner = 0;
      end else if (m_ten == TO - 1) begin
        m_err   = 1'b1;
        stalled = m_owner;
        m_owner = 0;
      end else begin
        m_ten++;
      end
      for (int i = 1; i < 4; i++) if (!req[i]) m_blk[i] = 1'b0;
      if (stalled != 0) m_blk[stalled] = 1'b1;
    end
  end

  // Monitor: pops the expected grant whenever one is due or any *_en is seen.
  always @(negedge sys_clk) begin
    logic [2:0]  act_en;
    logic [2:0]  exp_en;
    logic [17:0] exp_pins;
    int          idx;
    if (mon_on) begin
      act_en = {rd_en, wr_en, atref_en};
      exp_en = 3'b000;
      if ((act_en != 3'b000) || ((exp_q.size() > 0) && (exp_q[0].cyc == cyc))) begin
        if ((exp_q.size() > 0) && (exp_q[0].cyc == cyc)) begin
          exp_en = 3'b001 << (exp_q[0].id - 1);
          void'(exp_q.pop_front());
        end
        chk("grant", {29'd0, act_en}, {29'd0, exp_en});
      end
      idx = m_init_done ? m_owner : 0;
      if (m_init_done && (m_owner == 0)) exp_pins = {4'b0111, {BW{1'b1}}, {AW{1'b1}}};
      else                               exp_pins = {cmd[idx], bank[idx], addr[idx]};
      chk("pins", {14'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {14'd0, exp_pins});
      chk("arb_err", {31'd0, arb_err}, {31'd0, m_err});
      chk("cke", {31'd0, sdram_cke}, 32'd1);
    end
  end

  // Requester behaviour: random requests, 0..6 cycle tenures, occasional stalls,
  // stray *_end pulses, and the odd reset landing in the middle of a read.
  initial begin
    bit started [4];
    int dur [4];
    int init_hold;
    init_hold = 0;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; endp[i] = 1'b0; started[i] = 1'b0; dur[i] = 0;
      cmd[i] = 4'd0; bank[i] = '0; addr[i] = '0;
    end
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    mon_on  = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(posedge sys_clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        cmd[k]  = 4'($urandom);
        bank[k] = BW'($urandom);
        addr[k] = AW'($urandom);
      end
      for (int i = 1; i < 4; i++) endp[i] = 1'b0;
      init_end = (c >= 100) && (c >= init_hold);
      if (sys_rst) begin
        sys_rst = 1'b0;
      end else if ((m_owner == 3) && (m_ten == 1) && ($urandom_range(0, 7) == 0)) begin
        sys_rst   = 1'b1;
        init_hold = c + 3 + int'($urandom_range(0, 5));
        init_end  = 1'b0;
        for (int i = 1; i < 4; i++) begin
          req[i] = 1'b0; started[i] = 1'b0;
        end
      end else begin
        for (int i = 1; i < 4; i++) begin
          if (m_init_done && (m_owner == i)) begin
            if (!started[i]) begin
              started[i] = 1'b1;
              dur[i] = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 6));
            end
            if (m_ten == dur[i]) endp[i] = 1'b1;
          end else if (started[i]) begin
            started[i] = 1'b0;
            if ((i == 1) || (dur[i] == 100) || ($urandom_range(0, 1) == 0)) req[i] = 1'b0;
          end else if (!req[i] && ($urandom_range(0, 5) == 0)) begin
            req[i] = 1'b1;
          end else if ($urandom_range(0, 39) == 0) begin
            endp[i] = 1'b1;
          end
        end
      end
    end
    repeat (3) @(posedge sys_clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL grant_drain actual=%0d pending expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
